// File: rtl/cram_store.sv
// rtl/cram_store.sv - CRAM control store, microinstruction register, diagnostic staging and parity.
// Microword bit 0 (PDP numbering) is vector bit WORD_W-1; segment k occupies the k-th 21-bit slice from the MSB.
module cram_store #(
  parameter int ADR_W  = 11,
  parameter int WORD_W = 84,
  parameter int SEG_W  = 21
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [ADR_W-1:0]  cradr,
  input  logic [3:0]        diag_seg_wr,
  input  logic              diag_commit,
  input  logic              diag_clr,
  input  logic [SEG_W-1:0]  ebus_data_in,
  input  logic [1:0]        diag_rd_sel,
  input  logic              diag_rd_en,
  output logic [WORD_W-1:0] cram_q,
  output logic [SEG_W-1:0]  ebus_data_out,
  output logic              ebus_driving,
  output logic              par_err,
  output logic              commit_err,
  output logic              stage_full
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADING,
    ST_FULL
  } state_t;

  logic [WORD_W-1:0] store [0:(1<<ADR_W)-1];

  state_t            state_q, state_d;
  logic [WORD_W-1:0] stage_q, stage_d;
  logic [3:0]        mask_q, mask_d;
  logic              commit_err_q, commit_err_d;
  logic              par_err_q, par_err_d;
  logic              chk_en_q;
  logic              store_we;

  always_comb begin
    stage_d      = stage_q;
    mask_d       = mask_q;
    state_d      = state_q;
    commit_err_d = commit_err_q;
    par_err_d    = par_err_q;
    store_we     = 1'b0;

    if (chk_en_q && !(^cram_q)) begin
      par_err_d = 1'b1;
    end

    // Clear happens first so a same-cycle segment write lands in a fresh mask.
    if (diag_clr) begin
      mask_d       = 4'b0000;
      commit_err_d = 1'b0;
      par_err_d    = 1'b0;
    end

    for (int s = 0; s < 4; s++) begin
      if (diag_seg_wr[s]) begin
        stage_d[WORD_W-1-s*SEG_W -: SEG_W] = ebus_data_in;
        mask_d[s] = 1'b1;
      end
    end

    if (diag_commit && !diag_clr) begin
      if (mask_d == 4'b1111) begin
        store_we = 1'b1;
        mask_d   = 4'b0000;
      end else begin
        commit_err_d = 1'b1;
      end
    end

    if (mask_d == 4'b1111) begin
      state_d = ST_FULL;
    end else if (mask_d != 4'b0000) begin
      state_d = ST_LOADING;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      stage_q      <= '0;
      mask_q       <= 4'b0000;
      commit_err_q <= 1'b0;
      par_err_q    <= 1'b0;
      chk_en_q     <= 1'b0;
      cram_q       <= '0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      mask_q       <= mask_d;
      commit_err_q <= commit_err_d;
      par_err_q    <= par_err_d;
      chk_en_q     <= 1'b1;
      cram_q       <= store[cradr];
    end
  end

  // Store is not reset; reading the array before writing gives read-before-write.
  always_ff @(posedge clk) begin
    if (!RESET && store_we) begin
      store[cradr] <= stage_d;
    end
  end

  always_comb begin
    ebus_data_out = '0;
    if (diag_rd_en) begin
      case (diag_rd_sel)
        2'd0:    ebus_data_out = cram_q[WORD_W-1 -: SEG_W];
        2'd1:    ebus_data_out = cram_q[WORD_W-1-SEG_W -: SEG_W];
        2'd2:    ebus_data_out = cram_q[WORD_W-1-2*SEG_W -: SEG_W];
        default: ebus_data_out = cram_q[WORD_W-1-3*SEG_W -: SEG_W];
      endcase
    end
  end

  assign ebus_driving = diag_rd_en;
  assign par_err      = par_err_q;
  assign commit_err   = commit_err_q;
  assign stage_full   = (state_q == ST_FULL);

endmodule

// File: tb/tb_cram_store.sv
// tb/tb_cram_store.sv - scoreboard bench for cram_store against a segment-level reference model.
module tb_cram_store;

  logic        clk = 1'b0;
  logic        RESET;
  logic [10:0] cradr;
  logic [3:0]  diag_seg_wr;
  logic        diag_commit;
  logic        diag_clr;
  logic [20:0] ebus_data_in;
  logic [1:0]  diag_rd_sel;
  logic        diag_rd_en;
  logic [83:0] cram_q;
  logic [20:0] ebus_data_out;
  logic        ebus_driving;
  logic        par_err;
  logic        commit_err;
  logic        stage_full;

  always #5 clk = ~clk;

  cram_store dut (
    .clk          (clk),
    .RESET        (RESET),
    .cradr        (cradr),
    .diag_seg_wr  (diag_seg_wr),
    .diag_commit  (diag_commit),
    .diag_clr     (diag_clr),
    .ebus_data_in (ebus_data_in),
    .diag_rd_sel  (diag_rd_sel),
    .diag_rd_en   (diag_rd_en),
    .cram_q       (cram_q),
    .ebus_data_out(ebus_data_out),
    .ebus_driving (ebus_driving),
    .par_err      (par_err),
    .commit_err   (commit_err),
    .stage_full   (stage_full)
  );

  typedef struct {
    logic [83:0] cram;
    logic        pe;
    logic        ce;
    logic        full;
    logic [20:0] rd;
    logic        drv;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the store as words, staging as four independent segments.
  logic [83:0] m_mem [0:2047];
  logic [20:0] m_stg [4];
  logic [3:0]  m_mask;
  logic        m_ce, m_pe, m_chk;
  logic [83:0] m_cram;

  function automatic logic [83:0] stg_word();
    return {m_stg[0], m_stg[1], m_stg[2], m_stg[3]};
  endfunction

  task automatic cmp(input string name, input logic [83:0] act, input logic [83:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [10:0] adr, input logic [3:0] seg,
                     input logic cm, input logic cl, input logic [20:0] din);
    logic [83:0] old;
    exp_t        e;
    @(negedge clk);
    #1;
    RESET        = r;
    cradr        = adr;
    diag_seg_wr  = seg;
    diag_commit  = cm;
    diag_clr     = cl;
    ebus_data_in = din;
    diag_rd_sel  = 2'($urandom_range(0, 3));
    diag_rd_en   = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (r) begin
      m_cram = '0;
      for (int k = 0; k < 4; k++) m_stg[k] = '0;
      m_mask = 4'b0000;
      m_ce   = 1'b0;
      m_pe   = 1'b0;
      m_chk  = 1'b0;
    end else begin
      if (m_chk && (^m_cram) == 1'b0) m_pe = 1'b1;
      old = m_mem[adr];
      if (cl) begin
        m_pe   = 1'b0;
        m_ce   = 1'b0;
        m_mask = 4'b0000;
      end
      for (int k = 0; k < 4; k++) begin
        if (seg[k]) begin
          m_stg[k]  = din;
          m_mask[k] = 1'b1;
        end
      end
      if (cm && !cl) begin
        if (m_mask == 4'b1111) begin
          m_mem[adr] = stg_word();
          m_mask     = 4'b0000;
        end else begin
          m_ce = 1'b1;
        end
      end
      m_cram = old;
      m_chk  = 1'b1;
    end
    e.cram = m_cram;
    e.pe   = m_pe;
    e.ce   = m_ce;
    e.full = (m_mask == 4'b1111);
    e.rd   = diag_rd_en ? 21'(m_cram >> (21 * (3 - int'(diag_rd_sel)))) : 21'h0;
    e.drv  = diag_rd_en;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [10:0] adr);
    cyc(1'b0, adr, 4'b0000, 1'b0, 1'b0, 21'h0);
  endtask

  task automatic seg_wr(input logic [3:0] seg, input logic [20:0] din);
    cyc(1'b0, 11'h000, seg, 1'b0, 1'b0, din);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("cram_q", cram_q, e.cram);
        cmp("par_err", par_err, e.pe);
        cmp("commit_err", commit_err, e.ce);
        cmp("stage_full", stage_full, e.full);
        cmp("ebus_data_out", ebus_data_out, e.rd);
        cmp("ebus_driving", ebus_driving, e.drv);
      end
    end
  end

  initial begin : driver
    logic [10:0] adr_tab [6];
    logic [83:0] word_a;
    logic [83:0] word_b;
    logic [3:0]  sw;
    adr_tab = '{11'h000, 11'h001, 11'h002, 11'h040, 11'h123, 11'h7FF};
    for (int i = 0; i < 2048; i++) m_mem[i] = '0;
    m_cram = '0;
    m_mask = 4'b0000;
    m_ce = 1'b0;
    m_pe = 1'b0;
    m_chk = 1'b0;
    for (int k = 0; k < 4; k++) m_stg[k] = '0;
    RESET = 1'b1; cradr = '0; diag_seg_wr = '0; diag_commit = 1'b0; diag_clr = 1'b0;
    ebus_data_in = '0; diag_rd_sel = '0; diag_rd_en = 1'b0;

    // Reset and the all-zero word at address 0
    cyc(1'b1, 11'h000, 4'b0000, 1'b0, 1'b0, 21'h0);
    #1 cmp("reset_cram", cram_q, 84'h0);
    cmp("reset_stage_full", stage_full, 1'b0);
    idle(11'h000);
    #1 cmp("par_suppressed", par_err, 1'b0);
    idle(11'h000);
    #1 cmp("par_even_zero", par_err, 1'b1);

    // Full staging and commit to 0x123
    cyc(1'b0, 11'h000, 4'b0000, 1'b0, 1'b1, 21'h0);
    seg_wr(4'b0001, 21'h1FFFFF);
    seg_wr(4'b0010, 21'h0);
    seg_wr(4'b0100, 21'h0);
    seg_wr(4'b1000, 21'h000001);
    #1 cmp("full_after_4", stage_full, 1'b1);
    cyc(1'b0, 11'h123, 4'b0000, 1'b1, 1'b0, 21'h0);
    #1 cmp("commit_ok_err", commit_err, 1'b0);
    cmp("full_dropped", stage_full, 1'b0);
    idle(11'h123);
    #1 cmp("readback_123", cram_q, {21'h1FFFFF, 42'h0, 21'h000001});

    // Incomplete staging commit
    seg_wr(4'b0001, 21'h0ABCDE);
    seg_wr(4'b0100, 21'h012345);
    cyc(1'b0, 11'h055, 4'b0000, 1'b1, 1'b0, 21'h0);
    #1 cmp("partial_commit_err", commit_err, 1'b1);
    cmp("partial_not_full", stage_full, 1'b0);
    idle(11'h055);
    #1 cmp("partial_store_kept", cram_q, 84'h0);
    cyc(1'b0, 11'h000, 4'b0000, 1'b0, 1'b1, 21'h0);
    #1 cmp("clr_commit_err", commit_err, 1'b0);

    // Read-before-write at 0x7FF
    word_a = {21'h0AAAAA, 21'h155555, 21'h000F0F, 21'h1234AB};
    word_b = {21'h1F0F0F, 21'h000111, 21'h0C0C0C, 21'h000007};
    for (int k = 0; k < 4; k++) seg_wr(4'(1 << k), 21'(word_a >> (21 * (3 - k))));
    cyc(1'b0, 11'h7FF, 4'b0000, 1'b1, 1'b0, 21'h0);
    for (int k = 0; k < 4; k++) seg_wr(4'(1 << k), 21'(word_b >> (21 * (3 - k))));
    cyc(1'b0, 11'h7FF, 4'b0000, 1'b1, 1'b0, 21'h0);
    #1 cmp("rbw_old", cram_q, word_a);
    idle(11'h7FF);
    #1 cmp("rbw_new", cram_q, word_b);

    // Sticky parity error
    seg_wr(4'b1111, 21'h0);
    cyc(1'b0, 11'h040, 4'b0000, 1'b1, 1'b0, 21'h0);
    seg_wr(4'b1111, 21'h0);
    seg_wr(4'b1000, 21'h000001);
    cyc(1'b0, 11'h041, 4'b0000, 1'b1, 1'b0, 21'h0);
    cyc(1'b0, 11'h041, 4'b0000, 1'b0, 1'b1, 21'h0);
    idle(11'h041);
    #1 cmp("par_good_clear", par_err, 1'b0);
    idle(11'h040);
    idle(11'h041);
    #1 cmp("par_set", par_err, 1'b1);
    idle(11'h041);
    #1 cmp("par_sticky", par_err, 1'b1);
    cyc(1'b0, 11'h041, 4'b0000, 1'b0, 1'b1, 21'h0);
    #1 cmp("par_clr", par_err, 1'b0);

    // Reset while loading
    seg_wr(4'b0001, 21'h000003);
    seg_wr(4'b0010, 21'h000005);
    cyc(1'b1, 11'h123, 4'b0000, 1'b0, 1'b0, 21'h0);
    #1 cmp("rst_load_full", stage_full, 1'b0);
    cmp("rst_load_cram", cram_q, 84'h0);
    cyc(1'b0, 11'h000, 4'b0000, 1'b1, 1'b0, 21'h0);
    #1 cmp("rst_load_commit_err", commit_err, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      sw = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      cyc(1'($urandom_range(0, 79) == 0), adr_tab[$urandom_range(0, 5)], sw,
          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 11) == 0),
          21'($urandom));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cram_store.md
Name: cram_store

Overview:
- Microcode control store and microinstruction register that sits directly downstream of the CRAM address logic.
- Takes the 11-bit CRAM address produced each EBOX cycle and registers the addressed 84-bit microword (80 data bits plus 4 spare/parity bits) so the field decoders can consume it.
- Provides the diagnostic load path from EBUS: four 21-bit segment writes are staged, then committed. It also provides diagnostic readback and sticky parity-error reporting.

Parameters:
- ADR_W, 11, CRAM address width (2K words)
- WORD_W, 84, microword width; bit 83 is the odd-parity bit over bits 0..82
- SEG_W, 21, diagnostic segment width (WORD_W/4)

Ports:
- clk  in  1  EBOX CRA clock
- RESET  in  1  synchronous, active-high reset
- cradr  in  11  current CRAM address [0:10], valid before posedge clk
- diag_seg_wr  in  4  one-hot segment write strobes; bit0=word[0:20], bit1=[21:41], bit2=[42:62], bit3=[63:83]
- diag_commit  in  1  write staged word into store at cradr
- diag_clr  in  1  clear staging mask, commit_err, par_err
- ebus_data_in  in  21  EBUS data[0:20] for segment writes
- diag_rd_sel  in  2  segment of cram_q selected for readback
- diag_rd_en  in  1  drive readback onto EBUS
- cram_q  out  84  registered microword
- ebus_data_out  out  21  readback data, 0 when diag_rd_en=0
- ebus_driving  out  1  equals diag_rd_en
- par_err  out  1  sticky CRAM parity error
- commit_err  out  1  sticky: commit attempted with incomplete staging
- stage_full  out  1  all four segments staged

Behaviour:
- Reset (clk edge with RESET=1): cram_q=0, staging=0, seg_mask=0, par_err=0, commit_err=0, state=IDLE. Store contents are not reset (simulation initial value 0). RESET overrides every other input in the same cycle.
- Read path:
  - Each posedge, cram_q <= store[cradr]. Latency is 1 clock from cradr to cram_q.
  - Read-before-write: if a commit targets the same address in the same cycle, cram_q gets the old contents.
- Parity:
  - One cycle after cram_q updates, par_err is set if XOR(cram_q[0:83])==0.
  - The check is suppressed on the cycle immediately after reset.
  - par_err stays sticky until RESET or diag_clr.
- Staging FSM, states IDLE, LOADING, FULL:
  - IDLE: any diag_seg_wr bit writes ebus_data_in into the matching staging segment and sets that seg_mask bit -> LOADING, or -> FULL if the mask reaches 4'b1111.
  - LOADING: further writes merge into staging; rewriting an already-loaded segment overwrites it. The state moves to FULL when the mask reaches 4'b1111.
  - FULL: stage_full=1; further segment writes still overwrite.
  - diag_commit in FULL: store[cradr] <= staging, merged with any same-cycle segment write. Then mask=0 -> IDLE. Staging data is retained.
  - diag_commit in IDLE or LOADING: no store write, commit_err<=1, state unchanged. If a same-cycle segment write completes the mask, the commit succeeds instead.
  - diag_clr: mask=0 -> IDLE, commit_err=0, par_err=0. diag_clr takes priority over a same-cycle commit; it does not take priority over a same-cycle segment write, which is applied after the clear.
  - More than one diag_seg_wr bit set: all selected segments load the same data. Legal.
- Readback is combinational: ebus_data_out = cram_q segment diag_rd_sel (0..3 maps to bits 0:20..63:83) when diag_rd_en, else 0.

Test Plan:
- Reset, then cradr=0 for 2 clocks -> cram_q=0. The check is suppressed on the first cycle, then par_err=1 because an all-zero word has even parity.
- Stage segments 0..3 with 21'h1FFFFF, 0, 0, 21'h000001; assert diag_commit with cradr=11'h123; one clock later present cradr=11'h123 -> cram_q={21'h1FFFFF,42'h0,21'h1}, commit_err=0, stage_full dropped after commit.
- Stage only segments 0 and 2, then diag_commit -> commit_err=1, store[cradr] unchanged, state LOADING. Then diag_clr -> commit_err=0, stage_full=0.
- Commit to 11'h7FF while cradr=11'h7FF with old contents X -> cram_q=X on that edge; new data appears on the following edge.
- Store a word with even parity at 11'h040, read it, then read an odd-parity word -> par_err set and held through the later good read; diag_clr clears it.
- Assert RESET in LOADING with mask 4'b0011 -> mask=0, stage_full=0, cram_q=0; a subsequent commit flags commit_err.
